vreg_lane_requester: RTL and testbench

Lane-side initiator for the vector-register crossbar: accepts one vector access command (read or write, register pointer, base address, element count), issues one `cntrl_req_t` element request per cycle toward its crossbar port, and advances on `reg_req_grant`. Read responses (`rsp_vld` plus register data) are captured into a small credit-protected buffer and streamed to the lane datapath. One instance per crossbar port.

---
 rtl/vreg_lane_requester_if.sv | 73 +++++++
 rtl/vreg_lane_requester.sv | 208 ++++++++++++++++++++
 tb/tb_vreg_lane_requester.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vreg_lane_requester_if.sv
// Shared types for the vector-register crossbar, plus the handshake bundle
// between one lane-side requester and its surroundings (command source,
// write-data source, crossbar port and read-data sink).
package vreg_core_pkg;
    localparam int NUM_OF_VECTOR_REG = 8;
    localparam int VECTOR_REG_DEPTH  = 16;
    localparam int VECTOR_REG_WIDTH  = 32;
    localparam int VREG_AW           = $clog2(VECTOR_REG_DEPTH);
    localparam int VREG_RW           = $clog2(NUM_OF_VECTOR_REG);

    localparam logic READ_REQ  = 1'b0;
    localparam logic WRITE_REQ = 1'b1;

    // One element request toward a crossbar port.
    typedef struct packed {
        logic                        vld;
        logic [VREG_RW-1:0]          vec_reg_ptr;
        logic [VREG_AW-1:0]          addr;
        logic                        access_type;
        logic [VREG_AW:0]            access_length;
        logic [VECTOR_REG_WIDTH-1:0] data;
    } cntrl_req_t;

    // Requester FSM state, also exported for observation.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } req_state_t;
endpackage

// Handshake rule for every vld/rdy pair below (cmd, wr_data, rd_data): a
// transfer happens on a rising clock edge where both valid and ready are 1;
// the producer holds valid and its payload stable until that transfer, and
// valid never depends on ready. The crossbar pair (vec_reg_req_port.vld /
// reg_req_grant) follows the same rule with the grant acting as ready.
interface vreg_lane_requester_if;
    logic                                        cmd_vld;
    logic                                        cmd_rdy;
    logic                                        cmd_type;
    logic [vreg_core_pkg::VREG_RW-1:0]           cmd_vec_reg;
    logic [vreg_core_pkg::VREG_AW-1:0]           cmd_base_addr;
    logic [vreg_core_pkg::VREG_AW:0]             cmd_length;
    logic                                        wr_data_vld;
    logic                                        wr_data_rdy;
    logic [vreg_core_pkg::VECTOR_REG_WIDTH-1:0]  wr_data;
    vreg_core_pkg::cntrl_req_t                   vec_reg_req_port;
    logic                                        reg_req_grant;
    logic                                        rsp_vld;
    logic [vreg_core_pkg::VECTOR_REG_WIDTH-1:0]  rsp_data;
    logic                                        rd_data_vld;
    logic                                        rd_data_rdy;
    logic [vreg_core_pkg::VECTOR_REG_WIDTH-1:0]  rd_data;

    // Requester side.
    modport master (
        input  cmd_vld, cmd_type, cmd_vec_reg, cmd_base_addr, cmd_length,
        input  wr_data_vld, wr_data,
        input  reg_req_grant, rsp_vld, rsp_data,
        input  rd_data_rdy,
        output cmd_rdy, wr_data_rdy, vec_reg_req_port, rd_data_vld, rd_data
    );

    // Environment side (command source, crossbar, data sinks).
    modport slave (
        output cmd_vld, cmd_type, cmd_vec_reg, cmd_base_addr, cmd_length,
        output wr_data_vld, wr_data,
        output reg_req_grant, rsp_vld, rsp_data,
        output rd_data_rdy,
        input  cmd_rdy, wr_data_rdy, vec_reg_req_port, rd_data_vld, rd_data
    );
endinterface

// File: rtl/vreg_lane_requester.sv
// Lane-side crossbar initiator: takes one vector access command, issues one
// element request per cycle, and buffers read responses behind a credit
// limit so the read-data buffer can never overflow.
module vreg_lane_requester
    import vreg_core_pkg::*;
#(
    parameter int RD_BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    vreg_lane_requester_if.master bus,
    output logic                  busy,
    output logic                  done,
    output req_state_t            state_dbg
);
    localparam int AW = VREG_AW;
    localparam int RW = VREG_RW;
    localparam int W  = VECTOR_REG_WIDTH;
    localparam int BW = $clog2(RD_BUF_DEPTH);
    localparam int CW = BW + 1;
    localparam int SW = ((AW + 1 > CW) ? AW + 1 : CW) + 1;

    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] BUF_ONE = CW'(1);

    req_state_t    state;
    req_state_t    state_nxt;

    // Latched command.
    logic          lat_type;
    logic [RW-1:0] lat_reg;
    logic [AW-1:0] lat_base;
    logic [AW:0]   lat_len;

    // Progress counters.
    logic [AW:0]   issued;
    logic [AW:0]   received;
    logic [AW:0]   outstanding;
    logic [AW:0]   received_nxt;

    // Read-data buffer.
    logic [W-1:0]  buf_mem [RD_BUF_DEPTH];
    logic [BW-1:0] wr_ptr;
    logic [BW-1:0] rd_ptr;
    logic [CW-1:0] buf_count;
    logic          buf_empty;

    // Datapath control.
    logic          cmd_rdy_int;
    logic          cmd_fire;
    logic [AW:0]   cmd_len_eff;
    logic          credit_ok;
    logic          req_vld;
    logic          req_fire;
    logic          last_fire;
    logic          rsp_push;
    logic          rd_pop;
    cntrl_req_t    req_port;

    // Handshake qualifiers, credit check and counter look-ahead.
    always_comb begin
        buf_empty    = (buf_count == '0);
        cmd_rdy_int  = (state == ST_IDLE) && buf_empty;
        cmd_fire     = bus.cmd_vld && cmd_rdy_int;
        cmd_len_eff  = (bus.cmd_length == '0) ? CNT_ONE : bus.cmd_length;
        outstanding  = issued - received;
        // Every issued-but-unanswered read will land in the buffer, so the
        // sum of in-flight and buffered elements is bounded by its depth.
        credit_ok    = (SW'(outstanding) + SW'(buf_count)) < SW'(RD_BUF_DEPTH);
        req_vld      = 1'b0;
        if (state == ST_REQ) begin
            req_vld = (lat_type == WRITE_REQ) ? bus.wr_data_vld : credit_ok;
        end
        req_fire     = req_vld && bus.reg_req_grant;
        last_fire    = req_fire && ((issued + CNT_ONE) == lat_len);
        // Responses only count while a read of ours is actually in flight.
        rsp_push     = bus.rsp_vld
                     && ((state == ST_REQ) || (state == ST_DRAIN))
                     && (lat_type == READ_REQ)
                     && (outstanding != '0);
        received_nxt = rsp_push ? (received + CNT_ONE) : received;
        rd_pop       = !buf_empty && bus.rd_data_rdy;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (last_fire) begin
                    state_nxt = (lat_type == WRITE_REQ) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Looking at the incoming response saves a cycle at the end.
                if (received_nxt == lat_len) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: status, crossbar request fields and write-data ready.
    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        state_dbg   = state;
        req_port    = '0;
        bus.wr_data_rdy = 1'b0;
        if (state == ST_REQ) begin
            req_port.vld           = req_vld;
            req_port.vec_reg_ptr   = lat_reg;
            req_port.addr          = lat_base + issued[AW-1:0];
            req_port.access_type   = lat_type;
            req_port.access_length = lat_len - issued;
            req_port.data          = (lat_type == WRITE_REQ) ? bus.wr_data : '0;
            bus.wr_data_rdy        = req_fire && (lat_type == WRITE_REQ);
        end
    end

    assign bus.vec_reg_req_port = req_port;
    assign bus.cmd_rdy          = cmd_rdy_int;
    assign bus.rd_data_vld      = !buf_empty;
    assign bus.rd_data          = buf_empty ? '0 : buf_mem[rd_ptr];

    // Capture the command fields on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_type <= READ_REQ;
            lat_reg  <= '0;
            lat_base <= '0;
            lat_len  <= '0;
        end else if (cmd_fire) begin
            lat_type <= bus.cmd_type;
            lat_reg  <= bus.cmd_vec_reg;
            lat_base <= bus.cmd_base_addr;
            lat_len  <= cmd_len_eff;
        end
    end

    // Issued / received element counters, restarted per command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued   <= '0;
            received <= '0;
        end else if (cmd_fire) begin
            issued   <= '0;
            received <= '0;
        end else begin
            if (req_fire) begin
                issued <= issued + CNT_ONE;
            end
            received <= received_nxt;
        end
    end

    // Read-data FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rsp_push) begin
                buf_mem[wr_ptr] <= bus.rsp_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (rd_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Read-data FIFO occupancy; push and pop together leave it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_count <= '0;
        end else begin
            case ({rsp_push, rd_pop})
                2'b10:   buf_count <= buf_count + BUF_ONE;
                2'b01:   buf_count <= buf_count - BUF_ONE;
                default: buf_count <= buf_count;
            endcase
        end
    end
endmodule

// File: tb/tb_vreg_lane_requester.sv
// Bench for vreg_lane_requester: a table of full-throughput commands plus
// hand-written sequences for credit stall, grant stall, write-data gap and
// mid-command reset. A small crossbar model answers grants from its own
// register memory; expected requests and read data come from the bench.
module tb_vreg_lane_requester;
    import vreg_core_pkg::*;

    localparam int DEPTH = VECTOR_REG_DEPTH;
    localparam int W     = VECTOR_REG_WIDTH;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic       done;
    req_state_t state_dbg;

    always #5 clk = ~clk;

    vreg_lane_requester_if bus();

    vreg_lane_requester #(.RD_BUF_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int accept_cyc = 0;
    int fire_cnt = 0;
    int wr_rdy_cnt = 0;
    int rd_cnt = 0;
    int cmd_seq = 0;

    logic       grant_en = 1'b0;
    logic       wr_allow = 1'b0;
    logic       rd_rdy_en = 1'b0;
    logic       cmd_pend = 1'b0;
    logic       rsp_pend = 1'b0;
    logic [W-1:0] rsp_pend_data = '0;

    cntrl_req_t   exp_req_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_src_q[$];

    logic [W-1:0] vmem    [NUM_OF_VECTOR_REG][DEPTH];
    logic [W-1:0] ref_mem [NUM_OF_VECTOR_REG][DEPTH];

    typedef struct {
        logic typ;
        int   rg;
        int   base;
        int   len;
        int   exp_done;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [W-1:0] init_word(input int r, input int a);
        return 32'h5000_0000 | 32'(r << 8) | 32'(a);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        cntrl_req_t act;
        cntrl_req_t expr;
        @(posedge clk);
        #1;
        cyc++;
        bus.cmd_vld       = cmd_pend;
        bus.rsp_vld       = rsp_pend;
        bus.rsp_data      = rsp_pend ? rsp_pend_data : '0;
        rsp_pend          = 1'b0;
        bus.reg_req_grant = grant_en;
        bus.wr_data_vld   = wr_allow && (wr_src_q.size() != 0);
        bus.wr_data       = (wr_src_q.size() != 0) ? wr_src_q[0] : '0;
        bus.rd_data_rdy   = rd_rdy_en;
        @(negedge clk);
        if (cmd_pend && bus.cmd_rdy) begin
            accept_cyc = cyc;
            cmd_pend   = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        act = bus.vec_reg_req_port;
        if (act.vld && !bus.reg_req_grant && exp_req_q.size() != 0) begin
            check("stall_hold", 64'(act), 64'(exp_req_q[0]));
        end
        if (act.vld && bus.reg_req_grant) begin
            fire_cnt++;
            check("req_expected", 64'(exp_req_q.size() != 0), 64'(1));
            if (exp_req_q.size() != 0) begin
                expr = exp_req_q.pop_front();
                check("req_fields", 64'(act), 64'(expr));
            end
            if (act.access_type == WRITE_REQ) begin
                vmem[int'(act.vec_reg_ptr)][int'(act.addr)] = act.data;
            end else begin
                rsp_pend      = 1'b1;
                rsp_pend_data = vmem[int'(act.vec_reg_ptr)][int'(act.addr)];
            end
        end
        if (bus.wr_data_rdy) begin
            wr_rdy_cnt++;
            if (wr_src_q.size() != 0) begin
                void'(wr_src_q.pop_front());
            end
        end
        if (bus.rd_data_vld && bus.rd_data_rdy) begin
            rd_cnt++;
            check("rd_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                check("rd_data", 64'(bus.rd_data), 64'(exp_q.pop_front()));
            end
        end
    endtask

    // Queue expectations for a command, present it, wait for accept.
    task automatic start_cmd(input logic typ, input int rg, input int base, input int len);
        int         n;
        int         a;
        logic [W-1:0] word;
        cntrl_req_t e;
        n = (len == 0) ? 1 : len;
        cmd_seq++;
        for (int i = 0; i < n; i++) begin
            a    = (base + i) % DEPTH;
            word = 32'h0000_000A + 32'(i) + 32'((cmd_seq - 1) * 256);
            e                = '0;
            e.vld            = 1'b1;
            e.vec_reg_ptr    = VREG_RW'(rg);
            e.addr           = VREG_AW'(a);
            e.access_type    = typ;
            e.access_length  = (VREG_AW + 1)'(n - i);
            e.data           = (typ == WRITE_REQ) ? word : '0;
            exp_req_q.push_back(e);
            if (typ == WRITE_REQ) begin
                wr_src_q.push_back(word);
                ref_mem[rg][a] = word;
            end else begin
                exp_q.push_back(ref_mem[rg][a]);
            end
        end
        bus.cmd_type      = typ;
        bus.cmd_vec_reg   = VREG_RW'(rg);
        bus.cmd_base_addr = VREG_AW'(base);
        bus.cmd_length    = (VREG_AW + 1)'(len);
        cmd_pend          = 1'b1;
        for (int k = 0; k < 20 && cmd_pend; k++) begin
            step();
        end
        if (cmd_pend) begin
            check("accept_timeout", 64'(0), 64'(1));
            cmd_pend = 1'b0;
        end
    endtask

    // Step until the next done pulse; returns cycles from accept to done.
    task automatic wait_done(input int budget, output int off);
        int start;
        start = done_cnt;
        for (int k = 0; k < budget && done_cnt == start; k++) begin
            step();
        end
        if (done_cnt == start) begin
            check("done_timeout", 64'(0), 64'(1));
            off = -1;
        end else begin
            off = done_cyc - accept_cyc;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int off;
        int f0;
        int w0;
        int r0;
        int d0;

        vecs[0] = '{WRITE_REQ, 3, 0,         4,  5};
        vecs[1] = '{READ_REQ,  1, DEPTH - 2, 4,  6};
        vecs[2] = '{WRITE_REQ, 1, 15,        2,  3};
        vecs[3] = '{READ_REQ,  1, 15,        1,  3};
        vecs[4] = '{WRITE_REQ, 7, 5,         0,  2};
        vecs[5] = '{READ_REQ,  5, 8,         16, 18};
        vecs[6] = '{READ_REQ,  3, 0,         4,  6};

        for (int r = 0; r < NUM_OF_VECTOR_REG; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                vmem[r][a]    = init_word(r, a);
                ref_mem[r][a] = init_word(r, a);
            end
        end

        bus.cmd_vld       = 1'b0;
        bus.cmd_type      = READ_REQ;
        bus.cmd_vec_reg   = '0;
        bus.cmd_base_addr = '0;
        bus.cmd_length    = '0;
        bus.wr_data_vld   = 1'b0;
        bus.wr_data       = '0;
        bus.reg_req_grant = 1'b0;
        bus.rsp_vld       = 1'b0;
        bus.rsp_data      = '0;
        bus.rd_data_rdy   = 1'b0;

        // Reset values.
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        check("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'(1));
        check("rst_req_port", 64'(bus.vec_reg_req_port), 64'(0));
        check("rst_wr_rdy", 64'(bus.wr_data_rdy), 64'(0));
        check("rst_rd_vld", 64'(bus.rd_data_vld), 64'(0));
        check("rst_rd_data", 64'(bus.rd_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        #10 reset = 1'b1;
        step();

        // Full-throughput command table.
        foreach (vecs[v]) begin
            w0 = wr_rdy_cnt;
            r0 = rd_cnt;
            grant_en  = 1'b1;
            wr_allow  = 1'b1;
            rd_rdy_en = 1'b1;
            start_cmd(vecs[v].typ, vecs[v].rg, vecs[v].base, vecs[v].len);
            wait_done(40, off);
            check($sformatf("v%0d_done_latency", v), 64'(off), 64'(vecs[v].exp_done));
            step();
            check($sformatf("v%0d_idle_busy", v), 64'(busy), 64'(0));
            check($sformatf("v%0d_idle_cmd_rdy", v), 64'(bus.cmd_rdy), 64'(1));
            if (vecs[v].typ == WRITE_REQ) begin
                check($sformatf("v%0d_wr_rdy_pulses", v), 64'(wr_rdy_cnt - w0),
                      64'((vecs[v].len == 0) ? 1 : vecs[v].len));
            end else begin
                check($sformatf("v%0d_rd_outputs", v), 64'(rd_cnt - r0),
                      64'((vecs[v].len == 0) ? 1 : vecs[v].len));
            end
        end

        // Read length 8 with the sink stalled: credits cap issue at 4.
        grant_en  = 1'b1;
        rd_rdy_en = 1'b0;
        f0 = fire_cnt;
        r0 = rd_cnt;
        start_cmd(READ_REQ, 2, 0, 8);
        repeat (10) step();
        check("credit_fires", 64'(fire_cnt - f0), 64'(4));
        check("credit_vld_low", 64'(bus.vec_reg_req_port.vld), 64'(0));
        check("credit_rd_vld", 64'(bus.rd_data_vld), 64'(1));
        check("credit_no_pop", 64'(rd_cnt - r0), 64'(0));
        rd_rdy_en = 1'b1;
        wait_done(60, off);
        repeat (4) step();
        check("credit_rd_outputs", 64'(rd_cnt - r0), 64'(8));
        check("credit_fires_total", 64'(fire_cnt - f0), 64'(8));
        check("credit_cmd_rdy", 64'(bus.cmd_rdy), 64'(1));

        // Write with the grant held low for 3 cycles.
        grant_en = 1'b0;
        wr_allow = 1'b1;
        f0 = fire_cnt;
        w0 = wr_rdy_cnt;
        start_cmd(WRITE_REQ, 4, 2, 4);
        repeat (3) step();
        check("stall_no_fire", 64'(fire_cnt - f0), 64'(0));
        check("stall_no_wr_rdy", 64'(wr_rdy_cnt - w0), 64'(0));
        check("stall_len_held", 64'(bus.vec_reg_req_port.access_length), 64'(4));
        grant_en = 1'b1;
        wait_done(40, off);
        check("stall_done_latency", 64'(off), 64'(8));
        check("stall_wr_rdy_pulses", 64'(wr_rdy_cnt - w0), 64'(4));

        // Write with a two-cycle write-data gap after two elements.
        grant_en = 1'b1;
        wr_allow = 1'b1;
        step();
        f0 = fire_cnt;
        w0 = wr_rdy_cnt;
        start_cmd(WRITE_REQ, 6, 9, 4);
        step();
        step();
        wr_allow = 1'b0;
        step();
        check("gap_vld_low_0", 64'(bus.vec_reg_req_port.vld), 64'(0));
        step();
        check("gap_vld_low_1", 64'(bus.vec_reg_req_port.vld), 64'(0));
        check("gap_fires", 64'(fire_cnt - f0), 64'(2));
        wr_allow = 1'b1;
        wait_done(40, off);
        check("gap_done_latency", 64'(off), 64'(7));
        check("gap_wr_rdy_pulses", 64'(wr_rdy_cnt - w0), 64'(4));
        step();
        r0 = rd_cnt;
        rd_rdy_en = 1'b1;
        start_cmd(READ_REQ, 6, 9, 4);
        wait_done(40, off);
        step();
        check("gap_readback_count", 64'(rd_cnt - r0), 64'(4));

        // Reset in the middle of a read with responses in flight.
        grant_en  = 1'b1;
        rd_rdy_en = 1'b0;
        d0 = done_cnt;
        start_cmd(READ_REQ, 1, 0, 8);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_vld", 64'(bus.vec_reg_req_port.vld), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_rd_vld", 64'(bus.rd_data_vld), 64'(0));
        check("mid_rst_rd_data", 64'(bus.rd_data), 64'(0));
        check("mid_rst_wr_rdy", 64'(bus.wr_data_rdy), 64'(0));
        check("mid_rst_cmd_rdy", 64'(bus.cmd_rdy), 64'(1));
        rsp_pend = 1'b0;
        exp_req_q.delete();
        exp_q.delete();
        wr_src_q.delete();
        step();
        step();
        #2 reset = 1'b1;
        step();
        check("mid_rst_no_done", 64'(done_cnt - d0), 64'(0));
        check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
        r0 = rd_cnt;
        rd_rdy_en = 1'b1;
        start_cmd(READ_REQ, 1, DEPTH - 2, 4);
        wait_done(40, off);
        check("post_rst_done_latency", 64'(off), 64'(6));
        step();
        check("post_rst_rd_outputs", 64'(rd_cnt - r0), 64'(4));

        check("end_req_queue_empty", 64'(exp_req_q.size()), 64'(0));
        check("end_rd_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
